// File: rtl/prefix32_result_stage.sv
// Result stage behind a fixed-latency 32-bit prefix adder: carries tag/MSBs through a LATENCY-deep
// line, captures sum/cout with NZCV flags into a FWFT FIFO. Optional macro: PREFIX32_RES_PARITY_EN.
module prefix32_result_stage #(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [3:0]  issue_tag,
  input  logic        issue_a31,
  input  logic        issue_b31,
  input  logic [31:0] sum,
  input  logic        cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_tag,
  output logic [3:0]  res_flags
`ifdef PREFIX32_RES_PARITY_EN
  ,
  output logic        res_par
`endif
);

  // DEPTH is a power of two >= 2, so pointers wrap by natural overflow.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshakes: an issue fires when issue_valid && issue_ready at a rising edge; a result pops when
  // res_valid && res_ready at a rising edge. Payloads must be stable while valid is high and ready low.

  logic [LATENCY-1:0] r_dl_valid;
  logic [3:0]         r_dl_tag [LATENCY];
  logic               r_dl_a31 [LATENCY];
  logic               r_dl_b31 [LATENCY];

  logic [31:0]        r_mem_data  [DEPTH];
  logic [3:0]         r_mem_tag   [DEPTH];
  logic [3:0]         r_mem_flags [DEPTH];
`ifdef PREFIX32_RES_PARITY_EN
  logic               r_mem_par   [DEPTH];
`endif

  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_fifo_count;
  logic [CW-1:0]      r_inflight;

  logic [CW:0]        w_occupancy;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [3:0]         w_flags;

  // Occupancy counts every accepted op, so a result leaving the line always has a free slot.
  assign w_occupancy = {1'b0, r_fifo_count} + {1'b0, r_inflight};
  assign issue_ready = !flush && (w_occupancy < (CW + 1)'(DEPTH));
  assign w_accept    = issue_valid && issue_ready;
  assign w_push      = r_dl_valid[LATENCY-1];
  assign res_valid   = (r_fifo_count != '0);
  assign w_pop       = res_valid && res_ready;

  assign w_flags = {sum[31],
                    (sum == 32'd0),
                    cout,
                    (r_dl_a31[LATENCY-1] == r_dl_b31[LATENCY-1]) && (sum[31] != r_dl_a31[LATENCY-1])};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dl_valid <= '0;
    end else if (flush) begin
      r_dl_valid <= '0;
    end else begin
      r_dl_valid[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
      end
    end
  end

  // Payload shifts every cycle; only the valid bit decides whether it means anything.
  always_ff @(posedge clk) begin
    r_dl_tag[0] <= issue_tag;
    r_dl_a31[0] <= issue_a31;
    r_dl_b31[0] <= issue_b31;
    for (int i = 1; i < LATENCY; i++) begin
      r_dl_tag[i] <= r_dl_tag[i-1];
      r_dl_a31[i] <= r_dl_a31[i-1];
      r_dl_b31[i] <= r_dl_b31[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr]  <= sum;
      r_mem_tag[r_wr_ptr]   <= r_dl_tag[LATENCY-1];
      r_mem_flags[r_wr_ptr] <= w_flags;
`ifdef PREFIX32_RES_PARITY_EN
      r_mem_par[r_wr_ptr]   <= ^sum;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
      r_inflight   <= '0;
    end else if (flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
      r_inflight   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CW'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CW'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Outputs are forced to zero when empty so reset clears them without resetting the storage.
  always_comb begin
    res_data  = '0;
    res_tag   = '0;
    res_flags = '0;
    if (res_valid) begin
      res_data  = r_mem_data[r_rd_ptr];
      res_tag   = r_mem_tag[r_rd_ptr];
      res_flags = r_mem_flags[r_rd_ptr];
    end
  end

`ifdef PREFIX32_RES_PARITY_EN
  always_comb begin
    res_par = 1'b0;
    if (res_valid) res_par = r_mem_par[r_rd_ptr];
  end
`endif

endmodule

// File: tb/tb_prefix32_result_stage.sv
// Directed bench for prefix32_result_stage: a bench-side adder replays each presented sum LATENCY
// cycles later; each task drives one scenario and compares against hand-derived values.
`timescale 1ns/1ps
module tb_prefix32_result_stage;
  localparam int LATENCY = 5;
  localparam int DEPTH   = 8;

  logic        clk, reset, flush;
  logic        issue_valid, issue_ready, issue_a31, issue_b31, cout;
  logic        res_valid, res_ready;
  logic [3:0]  issue_tag, res_tag, res_flags;
  logic [31:0] sum, res_data;
`ifdef PREFIX32_RES_PARITY_EN
  logic        res_par;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [39:0] exp_q[$];

  logic [31:0] in_sum;
  logic        in_cout;
  logic [31:0] p_sum  [LATENCY];
  logic        p_cout [LATENCY];

  prefix32_result_stage #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .issue_a31(issue_a31), .issue_b31(issue_b31), .sum(sum), .cout(cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_flags(res_flags)
`ifdef PREFIX32_RES_PARITY_EN
    , .res_par(res_par)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Adder model: whatever is presented in cycle t appears on sum/cout during cycle t+LATENCY.
  always @(posedge clk) begin
    for (int i = LATENCY - 1; i > 0; i--) begin
      p_sum[i]  = p_sum[i-1];
      p_cout[i] = p_cout[i-1];
    end
    p_sum[0]  = in_sum;
    p_cout[0] = in_cout;
    #1;
    sum  = p_sum[LATENCY-1];
    cout = p_cout[LATENCY-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    issue_tag   = 4'($urandom_range(0, 15));
    issue_a31   = 1'($urandom_range(0, 1));
    issue_b31   = 1'($urandom_range(0, 1));
    in_sum      = $urandom;
    in_cout     = 1'($urandom_range(0, 1));
  endtask

  task automatic present(input logic [3:0] t, input logic a, input logic b,
                         input logic [31:0] s, input logic c);
    issue_valid = 1'b1;
    issue_tag   = t;
    issue_a31   = a;
    issue_b31   = b;
    in_sum      = s;
    in_cout     = c;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; res_ready = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b want 0", res_valid); end
    n_cmp++; if (res_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %0h want 0", res_data); end
    n_cmp++; if (res_tag !== 4'h0) begin n_bad++; $display("FAIL rst_tag: got %0h want 0", res_tag); end
    n_cmp++; if (res_flags !== 4'h0) begin n_bad++; $display("FAIL rst_flags: got %0h want 0", res_flags); end
`ifdef PREFIX32_RES_PARITY_EN
    n_cmp++; if (res_par !== 1'b0) begin n_bad++; $display("FAIL rst_par: got %0b want 0", res_par); end
`endif
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b want 1", issue_ready); end
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      tick();
      if (c == 0) present(4'd3, 1'b0, 1'b0, 32'h0, 1'b1);
      else idle_inputs();
      @(negedge clk);
      if (c == 0) begin
        n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %0b want 1", issue_ready); end
      end else if (c == 6) begin
        n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid c6: got %0b want 1", res_valid); end
        n_cmp++; if (res_data !== 32'h0) begin n_bad++; $display("FAIL single_data: got %0h want 0", res_data); end
        n_cmp++; if (res_tag !== 4'd3) begin n_bad++; $display("FAIL single_tag: got %0h want 3", res_tag); end
        n_cmp++; if (res_flags !== 4'b0110) begin n_bad++; $display("FAIL single_flags: got %b want 0110", res_flags); end
      end else begin
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL single_idle c%0d: got %0b want 0", c, res_valid); end
      end
    end
  endtask

  task automatic test_overflow();
    res_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      tick();
      if (c == 0)      present(4'd5, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1);
      else if (c == 1) present(4'd6, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
      else             idle_inputs();
      @(negedge clk);
      if (c == 6) begin
        n_cmp++; if ({res_valid, res_tag, res_data} !== {1'b1, 4'd5, 32'h7FFF_FFFF})
          begin n_bad++; $display("FAIL ovf1_word: got v%0b t%0h d%0h want v1 t5 d7fffffff", res_valid, res_tag, res_data); end
        n_cmp++; if (res_flags !== 4'b0011) begin n_bad++; $display("FAIL ovf1_flags: got %b want 0011", res_flags); end
      end else if (c == 7) begin
        n_cmp++; if ({res_valid, res_tag, res_data} !== {1'b1, 4'd6, 32'h8000_0000})
          begin n_bad++; $display("FAIL ovf2_word: got v%0b t%0h d%0h want v1 t6 d80000000", res_valid, res_tag, res_data); end
        n_cmp++; if (res_flags !== 4'b1001) begin n_bad++; $display("FAIL ovf2_flags: got %b want 1001", res_flags); end
      end else if (c == 8 || c < 6) begin
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_idle c%0d: got %0b want 0", c, res_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [39:0] e;
    acc = 0;
    res_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      present(4'(acc), 1'b0, 1'b0, 32'h100 + 32'(acc), 1'b0);
      @(negedge clk);
      n_cmp++; if (issue_ready !== (c < DEPTH)) begin n_bad++; $display("FAIL bp_ready c%0d: got %0b want %0b", c, issue_ready, c < DEPTH); end
      if (issue_ready) begin
        exp_q.push_back({4'(acc), 4'b0000, 32'h100 + 32'(acc)});
        acc++;
      end
    end
    n_cmp++; if (acc != DEPTH) begin n_bad++; $display("FAIL bp_accepted: got %0d want %0d", acc, DEPTH); end
    for (int k = 0; k <= DEPTH; k++) begin
      tick();
      idle_inputs();
      res_ready = 1'b1;
      @(negedge clk);
      if (k < DEPTH) begin
        n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL bp_drain_valid k%0d: got %0b want 1", k, res_valid); end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_cmp++; if ({res_tag, res_flags, res_data} !== e)
            begin n_bad++; $display("FAIL bp_drain_word k%0d: got %h want %h", k, {res_tag, res_flags, res_data}, e); end
        end
        n_cmp++; if (issue_ready !== (k >= 1)) begin n_bad++; $display("FAIL bp_ready_return k%0d: got %0b want %0b", k, issue_ready, k >= 1); end
      end else begin
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %0b want 0", res_valid); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  t;
    logic [39:0] e;
    res_ready = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      tick();
      if (c < 16) begin
        t = 4'(c);
        present(t, 1'b0, 1'b0, {t, 28'h0}, t[0]);
        exp_q.push_back({t, {t[3], (t == 4'd0), t[0], t[3]}, {t, 28'h0}});
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (c < 16) begin
        n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready c%0d: got %0b want 1", c, issue_ready); end
      end
      n_cmp++; if (res_valid !== (c >= 6 && c <= 21)) begin n_bad++; $display("FAIL b2b_valid c%0d: got %0b want %0b", c, res_valid, c >= 6 && c <= 21); end
      if (res_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++; if ({res_tag, res_flags, res_data} !== e)
          begin n_bad++; $display("FAIL b2b_word c%0d: got %h want %h", c, {res_tag, res_flags, res_data}, e); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_flush();
    res_ready = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      tick();
      flush = (c == 7);
      if (c < 5 || c == 7) present(4'(9 + c), 1'b0, 1'b0, 32'(9 + c), 1'b0);
      else idle_inputs();
      if (c >= 8) res_ready = 1'b1;
      @(negedge clk);
      if (c == 7) begin
        n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready_low: got %0b want 0", issue_ready); end
        n_cmp++; if ({res_valid, res_tag} !== {1'b1, 4'd9}) begin n_bad++; $display("FAIL flush_pre_head: got v%0b t%0h want v1 t9", res_valid, res_tag); end
      end else if (c == 8) begin
        n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready_back: got %0b want 1", issue_ready); end
      end
      if (c >= 8) begin
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_result c%0d: got %0b want 0", c, res_valid); end
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      tick();
      if (c < 6) present(4'(c + 1), 1'b0, 1'b0, 32'(c + 1), 1'b0);
      else idle_inputs();
      @(negedge clk);
    end
    n_cmp++; if ({res_valid, res_tag} !== {1'b1, 4'd1}) begin n_bad++; $display("FAIL rmid_head: got v%0b t%0h want v1 t1", res_valid, res_tag); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if ({res_valid, res_data, res_tag, res_flags} !== 41'h0)
      begin n_bad++; $display("FAIL rmid_async_clear: got v%0b d%0h t%0h f%0h want all 0", res_valid, res_data, res_tag, res_flags); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      idle_inputs();
      res_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_result c%0d: got %0b want 0", c, res_valid); end
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready c%0d: got %0b want 1", c, issue_ready); end
    end
  endtask

`ifdef PREFIX32_RES_PARITY_EN
  task automatic test_parity();
    res_ready = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      tick();
      if (c == 0)      present(4'd2, 1'b0, 1'b0, 32'h0000_0007, 1'b0);
      else if (c == 1) present(4'd4, 1'b0, 1'b0, 32'h0000_0003, 1'b0);
      else             idle_inputs();
      @(negedge clk);
      if (c == 6) begin
        n_cmp++; if ({res_valid, res_data, res_par} !== {1'b1, 32'h7, 1'b1}) begin n_bad++; $display("FAIL par_odd: got v%0b d%0h p%0b want v1 d7 p1", res_valid, res_data, res_par); end
      end else if (c == 7) begin
        n_cmp++; if ({res_valid, res_data, res_par} !== {1'b1, 32'h3, 1'b0}) begin n_bad++; $display("FAIL par_even: got v%0b d%0h p%0b want v1 d3 p0", res_valid, res_data, res_par); end
      end
    end
  endtask
`endif

  initial begin
    flush = 1'b0; issue_valid = 1'b0; res_ready = 1'b0;
    issue_tag = 4'h0; issue_a31 = 1'b0; issue_b31 = 1'b0;
    in_sum = 32'h0; in_cout = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef PREFIX32_RES_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prefix32_result_stage.md
PREFIX32_RESULT_STAGE -- requirements
Module: prefix32_result_stage

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- LATENCY, 5, adder pipeline depth in cycles, operand presentation to sum/cout valid
- DEPTH, 8, result FIFO entries, power of two, DEPTH >= LATENCY
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all in-flight and buffered results
- issue_valid  in  1  operands presented to the adder this cycle
- issue_ready  out  1  block can absorb one more result
- issue_tag  in  4  op identifier travelling with the op
- issue_a31  in  1  MSB of operand a driven into the adder
- issue_b31  in  1  MSB of the effective operand b driven into the adder, after any subtract inversion
- sum  in  32  adder sum output
- cout  in  1  adder carry output
- res_valid  out  1  FIFO head holds a result
- res_ready  in  1  consumer accepts the head
- res_data  out  32  result word
- res_tag  out  4  tag of the result
- res_flags  out  4  {N,Z,C,V}
REQ-003 The interface SHALL have one clock, clk, and reset SHALL be asynchronous and active-low, named reset.

Function
REQ-004 An issue is accepted when issue_valid && issue_ready in cycle t.
REQ-005 On acceptance, {valid, tag, a31, b31} SHALL enter a LATENCY-stage delay line.
- The matching sum/cout are sampled in cycle t+LATENCY.
- The result is written to the FIFO at the edge ending cycle t+LATENCY.
REQ-006 res_valid SHALL assert no earlier than cycle t+LATENCY+1, so end-to-end latency is LATENCY+1 when the FIFO is empty.
REQ-007 issue_valid without issue_ready SHALL inject a bubble, not an op.
- The upstream source holds the op.
- sum/cout in bubble cycles SHALL be ignored.
REQ-008 issue_ready SHALL equal (fifo_count + inflight_count) < DEPTH.
- Both counts are registered.
- issue_ready has no combinational path from res_ready or issue_valid.
- A pop in cycle t frees a slot from cycle t+1.
REQ-009 A result arriving from the delay line SHALL always find a free entry; no result is ever dropped.
REQ-010 Flags SHALL be:
- N = sum[31]
- Z = (sum == 0)
- C = cout
- V = (a31 == b31) && (sum[31] != a31)
- All computed on capture and stored with the entry.
REQ-011 A pop occurs when res_valid && res_ready.
- The FIFO is first-word-fall-through.
- Order is strict issue order.
- Pointers wrap modulo DEPTH.
REQ-012 A simultaneous push and pop SHALL leave fifo_count unchanged.
- A push to an empty FIFO is visible on res_valid the next cycle.
- There is no same-cycle bypass.
REQ-013 res_data, res_tag, res_flags SHALL hold stable while res_valid && !res_ready.
REQ-014 flush high at an edge SHALL clear:
- all delay-line valid bits
- FIFO pointers and count
- Any issue accepted in the flush cycle is discarded.
- issue_ready SHALL be 0 in the flush cycle.
REQ-015 With no accepted issue and an empty delay line, FIFO contents and outputs SHALL be unchanged.

Reset
REQ-016 reset low SHALL immediately clear:
- delay-line valid bits, FIFO pointers, counts
- res_valid = 0, res_data = 0, res_tag = 0, res_flags = 0
- issue_ready SHALL read 1 while reset is high and the block is empty.
REQ-017 Reset mid-operation SHALL discard all in-flight and buffered results; none appears after release.
REQ-018 Deassertion is synchronised externally; the block needs no reset synchroniser.

Configuration
REQ-019 Macro PREFIX32_RES_PARITY_EN defined:
- extra output res_par (1 bit) = even parity, XOR of res_data bits, computed at capture and stored per entry
- res_par resets to 0
REQ-020 Macro PREFIX32_RES_PARITY_EN undefined: port res_par and its storage SHALL be absent; all other behaviour identical.

Verification
REQ-021 Single op: tag 3, sum 0x00000000, cout 1, a31 0, b31 0 at cycle 0+5 -> res_valid at cycle 6, res_data 0, res_tag 3, flags {N0,Z1,C1,V0}.
REQ-022 Overflow: a31 1, b31 1, sum 0x7FFFFFFF, cout 1 -> flags {0,0,1,1}; a31 0, b31 0, sum 0x80000000 -> {1,0,0,1}.
REQ-023 Backpressure: res_ready 0, issue_valid 1 continuously -> exactly 8 issues accepted, issue_ready 0 thereafter; release res_ready -> 8 results in tag order, issue_ready returns 1 the cycle after the first pop.
REQ-024 Streaming: res_ready 1, back-to-back issues tags 0..15 -> one result per cycle from cycle 6, no bubbles, tags in order, pointers wrap twice.
REQ-025 Flush with 3 in flight and 2 buffered -> res_valid 0 next cycle, no further results, issue_ready 1 next cycle.
REQ-026 reset low mid-stream with 4 buffered -> outputs 0 asynchronously, no result after release; with PREFIX32_RES_PARITY_EN, sum 0x00000007 -> res_par 1.
